// File: rtl/ts_pkt_slot_writer.sv
// Writes framed 32-bit TS packets into fixed-size slots of a DDR3 ring buffer and publishes the committed-slot pointer.
// Optional sync-byte check on every sop word is enabled by defining TS_SYNC_CHK_EN.
module ts_pkt_slot_writer #(
    parameter int PKT_WORDS = 47,
    parameter int SLOT_AW   = 6,
    parameter int SLOT_NW   = 10,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                sc_i_d,
    input  logic                       sc_i_dval,
    input  logic                       sc_i_sop,
    input  logic                       sc_i_eop,
    input  logic [SLOT_NW-1:0]         rd_slot_ptr,
    output logic                       wr_en,
    output logic [SLOT_NW+SLOT_AW-1:0] wr_addr,
    output logic [31:0]                wr_data,
    output logic [SLOT_NW-1:0]         wr_slot_ptr,
    output logic                       pkt_commit,
    output logic                       buf_full,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = SLOT_NW + SLOT_AW;
    localparam logic [SLOT_AW-1:0] LAST_OFF = SLOT_AW'(PKT_WORDS - 1);
    localparam logic [SLOT_AW-1:0] ONE_OFF  = SLOT_AW'(1);
    localparam logic [SLOT_NW-1:0] ONE_SLOT = SLOT_NW'(1);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t               state_reg, state_next;
    logic [SLOT_AW-1:0]   offset_reg, offset_next;
    logic [SLOT_NW-1:0]   slot_reg, slot_next;
    logic                 wr_en_reg, wr_en_next;
    logic [AW-1:0]        wr_addr_reg, wr_addr_next;
    logic [31:0]          wr_data_reg, wr_data_next;
    logic                 commit_reg, commit_next;
    logic [CNT_W-1:0]     err_reg, err_next;
    logic [CNT_W-1:0]     drop_reg, drop_next;
    logic [1:0]           err_inc;
    logic                 drop_inc;
    logic                 sync_ok;
    logic                 full;

    // One slot always stays empty so full and empty remain distinguishable.
    assign full = ((slot_reg + ONE_SLOT) == rd_slot_ptr);

`ifdef TS_SYNC_CHK_EN
    assign sync_ok = (sc_i_d[31:24] == 8'h47);
`else
    assign sync_ok = 1'b1;
`endif

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        state_next   = state_reg;
        offset_next  = offset_reg;
        slot_next    = slot_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        commit_next  = 1'b0;
        err_inc      = 2'd0;
        drop_inc     = 1'b0;

        if (sc_i_dval) begin
            if (sc_i_sop) begin
                // A sop always restarts framing; an open packet is abandoned first.
                if (state_reg == RECV) begin
                    err_inc = err_inc + 2'd1;
                end
                offset_next = '0;
                if (!sync_ok) begin
                    err_inc    = err_inc + 2'd1;
                    state_next = DROP;
                end else if (full) begin
                    drop_inc   = 1'b1;
                    state_next = DROP;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = {slot_reg, {SLOT_AW{1'b0}}};
                    wr_data_next = sc_i_d;
                    if (sc_i_eop) begin
                        state_next = IDLE;
                        if (PKT_WORDS == 1) begin
                            commit_next = 1'b1;
                        end else begin
                            err_inc = err_inc + 2'd1;
                        end
                    end else if (LAST_OFF == '0) begin
                        err_inc    = err_inc + 2'd1;
                        state_next = DROP;
                    end else begin
                        offset_next = ONE_OFF;
                        state_next  = RECV;
                    end
                end
            end else begin
                unique case (state_reg)
                    IDLE: err_inc = 2'd1;
                    RECV: begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = {slot_reg, offset_reg};
                        wr_data_next = sc_i_d;
                        if (sc_i_eop) begin
                            state_next  = IDLE;
                            offset_next = '0;
                            if (offset_reg == LAST_OFF) begin
                                commit_next = 1'b1;
                            end else begin
                                err_inc = 2'd1;
                            end
                        end else if (offset_reg == LAST_OFF) begin
                            err_inc     = 2'd1;
                            state_next  = DROP;
                            offset_next = '0;
                        end else begin
                            offset_next = offset_reg + ONE_OFF;
                        end
                    end
                    DROP: begin
                        if (sc_i_eop) begin
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        if (commit_next) begin
            slot_next = slot_reg + ONE_SLOT;
        end
        err_next  = sat_add(err_reg, err_inc);
        drop_next = sat_add(drop_reg, {1'b0, drop_inc});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            offset_reg  <= '0;
            slot_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            commit_reg  <= 1'b0;
            err_reg     <= '0;
            drop_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            offset_reg  <= offset_next;
            slot_reg    <= slot_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            commit_reg  <= commit_next;
            err_reg     <= err_next;
            drop_reg    <= drop_next;
        end
    end

    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign wr_slot_ptr = slot_reg;
    assign pkt_commit  = commit_reg;
    assign buf_full    = full;
    assign err_cnt     = err_reg;
    assign drop_cnt    = drop_reg;

endmodule

// File: tb/tb_ts_pkt_slot_writer.sv
// Randomized bench for ts_pkt_slot_writer: a packet-level model predicts every slot write, commit and counter value.
module tb_ts_pkt_slot_writer;
    localparam int PW  = 47;
    localparam int SAW = 6;
    localparam int SNW = 10;
    localparam int CW  = 16;
    localparam int NS  = 1 << SNW;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       sc_i_d;
    logic              sc_i_dval, sc_i_sop, sc_i_eop;
    logic [SNW-1:0]    rd_slot_ptr;
    logic              wr_en;
    logic [SNW+SAW-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [SNW-1:0]    wr_slot_ptr;
    logic              pkt_commit, buf_full;
    logic [CW-1:0]     err_cnt, drop_cnt;

    ts_pkt_slot_writer #(.PKT_WORDS(PW), .SLOT_AW(SAW), .SLOT_NW(SNW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sc_i_d(sc_i_d), .sc_i_dval(sc_i_dval), .sc_i_sop(sc_i_sop),
        .sc_i_eop(sc_i_eop), .rd_slot_ptr(rd_slot_ptr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_slot_ptr(wr_slot_ptr), .pkt_commit(pkt_commit),
        .buf_full(buf_full), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Record layout: {wr_en, pkt_commit, wr_addr, wr_data}
    logic [49:0] act_q[$];
    logic [49:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst && (wr_en || pkt_commit)) act_q.push_back({wr_en, pkt_commit, wr_addr, wr_data});
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Packet-level model: md 0 = between packets, 1 = packet open, 2 = discarding until eop.
    int m_slot = 0, m_err = 0, m_drop = 0, md = 0;
    bit bubbles = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_word(input logic [31:0] d, input bit s, input bit e);
        while (bubbles && $urandom_range(0, 5) == 0) begin
            @(posedge clk); #1;
        end
        sc_i_d = d; sc_i_sop = s; sc_i_eop = e; sc_i_dval = 1'b1;
        @(posedge clk); #1;
        sc_i_dval = 1'b0; sc_i_sop = 1'b0; sc_i_eop = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit has_eop, input bit bad_sync);
        bit full, cmt, sop_drop;
        int nw;
        logic [31:0] d, r;
        cmt = 0; nw = 0; sop_drop = 0;
        full = (((m_slot + 1) % NS) == int'(rd_slot_ptr));
        if (md == 1) m_err++;
        if (bad_sync) begin
            m_err++; md = 2; sop_drop = 1;
        end else if (full) begin
            m_drop++; md = 2; sop_drop = 1;
        end else begin
            nw = (len < PW) ? len : PW;
            if (len == PW && has_eop) cmt = 1;
            else if (has_eop || len >= PW) m_err++;
            md = (len >= PW) ? 2 : 1;
        end
        if (has_eop && !(sop_drop && len == 1)) md = 0;
        for (int i = 0; i < len; i++) begin
            r = $urandom;
            if (i == 0) d = {bad_sync ? 8'h12 : 8'h47, r[23:0]};
            else d = r;
            if (i < nw) exp_q.push_back({1'b1, cmt && (i == nw - 1), 10'(m_slot), 6'(i), d});
            drive_word(d, i == 0, has_eop && (i == len - 1));
        end
        if (cmt) m_slot = (m_slot + 1) % NS;
    endtask

    task automatic send_stray(input int n, input bit last_eop);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            if (md == 0) m_err++;
            drive_word(r, 1'b0, last_eop && (i == n - 1));
        end
        if (last_eop && md == 2) md = 0;
    endtask

    task automatic settle_check(input string tag);
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " nwrites"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s write%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
        act_q.delete(); exp_q.delete();
        chk({tag, " err_cnt"}, 64'(err_cnt), 64'(m_err));
        chk({tag, " drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
        chk({tag, " wr_slot_ptr"}, 64'(wr_slot_ptr), 64'(m_slot));
        chk({tag, " buf_full"}, 64'(buf_full), 64'(((m_slot + 1) % NS) == int'(rd_slot_ptr)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " wr_en"}, 64'(wr_en), 64'(0));
        chk({tag, " wr_addr"}, 64'(wr_addr), 64'(0));
        chk({tag, " wr_data"}, 64'(wr_data), 64'(0));
        chk({tag, " wr_slot_ptr"}, 64'(wr_slot_ptr), 64'(0));
        chk({tag, " pkt_commit"}, 64'(pkt_commit), 64'(0));
        chk({tag, " err_cnt"}, 64'(err_cnt), 64'(0));
        chk({tag, " drop_cnt"}, 64'(drop_cnt), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1; sc_i_d = '0; sc_i_dval = 0; sc_i_sop = 0; sc_i_eop = 0; rd_slot_ptr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset buf_full", 64'(buf_full), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Three back-to-back good packets into slots 0..2
        bubbles = 0;
        for (int p = 0; p < 3; p++) send_pkt(PW, 1, 0);
        settle_check("b2b3");
        bubbles = 1;

        // Short packet leaves an uncommitted slot; the next good one reuses it
        send_pkt(30, 1, 0);
        settle_check("short30");
        send_pkt(PW, 1, 0);
        settle_check("after_short");

        // Full buffer: slot 4, reader at 5
        rd_slot_ptr = 10'd5;
        settle_check("full_flag");
        send_pkt(PW, 1, 0);
        settle_check("full_drop");
        rd_slot_ptr = 10'd6;
        send_pkt(PW, 1, 0);
        settle_check("after_full");

        // New sop at word 20 aborts the open packet
        send_pkt(20, 0, 0);
        send_pkt(PW, 1, 0);
        settle_check("abort20");

        // Overlong packets, with and without eop on the 50th word
        send_pkt(50, 1, 0);
        settle_check("long50_eop");
        send_pkt(50, 0, 0);
        send_stray(3, 1);
        settle_check("long50_noeop");

        // Stray words between packets and a sop+eop single-word packet
        send_stray(3, 0);
        settle_check("stray3");
        send_pkt(1, 1, 0);
        settle_check("sop_eop");

        // Abort and full on the same sop word
        rd_slot_ptr = 10'(m_slot + 3);
        send_pkt(10, 0, 0);
        rd_slot_ptr = 10'(m_slot + 1);
        send_pkt(PW, 1, 0);
        settle_check("abort_full");

`ifdef TS_SYNC_CHK_EN
        rd_slot_ptr = 10'(m_slot + 5);
        send_pkt(PW, 1, 1);
        settle_check("bad_sync");
        send_pkt(PW, 1, 0);
        settle_check("after_bad_sync");
`endif

        // Randomized mix of packet kinds and reader positions
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) rd_slot_ptr = 10'(m_slot + $urandom_range(1, 3));
            r = $urandom_range(0, 9);
            case (r)
                5: send_pkt($urandom_range(1, PW - 1), 1, 0);
                6: send_pkt($urandom_range(PW + 1, 60), 1, 0);
                7: send_pkt($urandom_range(1, PW - 1), 0, 0);
                8: if (md == 0) send_stray($urandom_range(1, 3), 0); else send_pkt(PW, 1, 0);
                9: begin
                    rd_slot_ptr = 10'(m_slot + 1);
                    send_pkt(PW, 1, 0);
                end
                default: send_pkt(PW, 1, 0);
            endcase
            settle_check($sformatf("rand%0d", it));
        end

        // Wrap the ring: reader stays two slots ahead
        bubbles = 0;
        r = NS - m_slot + 1;
        for (int p = 0; p < r; p++) begin
            rd_slot_ptr = 10'(m_slot + 2);
            send_pkt(PW, 1, 0);
            if (m_slot <= 1) settle_check($sformatf("wrap_slot%0d", m_slot));
        end
        settle_check("wrap_end");
        chk("wrap ptr", 64'(wr_slot_ptr), 64'(1));

        // Reset in the middle of a packet
        rd_slot_ptr = 10'(m_slot + 4);
        drive_word(32'h4700_0001, 1, 0);
        for (int i = 1; i < 12; i++) drive_word($urandom, 0, 0);
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk); #1;
        check_zero("rst_edge");
        rst = 1'b0;
        act_q.delete(); exp_q.delete();
        m_slot = 0; m_err = 0; m_drop = 0; md = 0;
        rd_slot_ptr = '0;
        @(posedge clk); #1;
        send_pkt(PW, 1, 0);
        settle_check("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ts_pkt_slot_writer.md
Name: ts_pkt_slot_writer

Overview:
- Sits directly downstream of the DDR3-side clock-domain converter, in the clk domain.
- Receives a 32-bit TS word stream framed by sop/eop and writes each complete packet into a fixed-size slot of a DDR3 ring buffer.
- Drives word write strobes, addresses and data toward the DDR3 write path. The consumer sees a committed-slot write pointer.
- Checks framing and buffer occupancy. Malformed packets and packets arriving while the buffer is full are dropped.

Parameters:
- PKT_WORDS, 47, words per valid packet (188 bytes / 4).
- SLOT_AW, 6, word-offset bits per slot (64 words per slot; PKT_WORDS must be ≤ 2^SLOT_AW).
- SLOT_NW, 10, slot-index bits (1024 slots in the ring).
- CNT_W, 16, width of the error and drop counters.

Ports:
- clk  in  1  system/DDR3 user clock.
- rst  in  1  asynchronous, active-high reset.
- sc_i_d  in  32  packet data word; byte 0 is in [31:24].
- sc_i_dval  in  1  data word valid. There is no backpressure.
- sc_i_sop  in  1  first word of packet; qualified by dval.
- sc_i_eop  in  1  last word of packet; qualified by dval.
- rd_slot_ptr  in  SLOT_NW  consumer's next slot to read, in the clk domain.
- wr_en  out  1  word write strobe.
- wr_addr  out  SLOT_NW+SLOT_AW  word address, formed as {slot, offset}.
- wr_data  out  32  word data.
- wr_slot_ptr  out  SLOT_NW  next slot to fill; equals the count of committed packets modulo 2^SLOT_NW.
- pkt_commit  out  1  one-cycle pulse when a packet is committed.
- buf_full  out  1  asserted when wr_slot_ptr+1 == rd_slot_ptr.
- err_cnt  out  CNT_W  framing-error count; saturates at all-ones.
- drop_cnt  out  CNT_W  count of packets dropped because the buffer was full; saturates.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE and the word offset is 0.
- Registered outputs:
  - wr_en, wr_addr and wr_data appear exactly 1 cycle after the accepted input word.
  - pkt_commit and the wr_slot_ptr increment occur in the same cycle as the wr_en of the packet's last word.
- Full test:
  - buf_full is combinational from the registered wr_slot_ptr and rd_slot_ptr.
  - It is sampled only on a sop word. One slot is always kept empty.
- IDLE state:
  - dval&sop with buf_full=0: write the word at offset 0, offset:=1, go to RECV.
  - dval&sop with buf_full=1: drop_cnt++, go to DROP.
  - dval without sop: no write, err_cnt++ once per stray word.
- RECV state:
  - Each dval word is written at {wr_slot_ptr, offset}, then offset++.
  - dval&eop with offset == PKT_WORDS-1: write the word, commit (wr_slot_ptr++ with wrap 2^SLOT_NW-1→0, pkt_commit=1), go to IDLE.
  - dval&eop with any other length: write the word, no commit, err_cnt++, go to IDLE.
  - dval at offset == PKT_WORDS-1 without eop: no commit, err_cnt++, go to DROP.
  - dval&sop while in RECV: the current packet is aborted (err_cnt++). The word is then handled exactly as a sop in IDLE, including the full test.
- DROP state:
  - dval words are ignored, with no writes.
  - dval&eop goes to IDLE.
  - dval&sop is handled as in IDLE (restart). A sop+eop word in DROP is handled as a sop.
- sop&eop on the same word:
  - Committed if PKT_WORDS==1.
  - Otherwise err_cnt++, go to IDLE (the word at offset 0 is written but not committed).
- Uncommitted writes: aborted or erroneous packets leave words in the uncommitted slot. The next packet overwrites them, and the consumer never reads them because wr_slot_ptr has not advanced.
- Simultaneous events: if err_cnt and drop_cnt would both increment on the same word (abort followed by full), both increment.
- rst asserted mid-packet: everything is cleared immediately. The partial packet is lost and wr_slot_ptr returns to 0. The consumer is reset by the same rst.

Optional Feature:
- Macro: TS_SYNC_CHK_EN.
- When defined:
  - At every accepted sop, sc_i_d[31:24] must be 8'h47.
  - On mismatch: no write, err_cnt++, go to DROP. The full test is skipped and drop_cnt is not incremented.
- When undefined: the sync byte is not checked.

Test Plan:
- 3 back-to-back 47-word packets (sop word 0x47000001), rd_slot_ptr=0 → 141 wr_en; wr_addr slot 0/1/2 offsets 0..46; 3 pkt_commit pulses; wr_slot_ptr=3; err_cnt=0.
- Packet with eop at word 30 → 30 wr_en, no pkt_commit, err_cnt=1. The following good packet lands in the same slot and commits.
- rd_slot_ptr=5, wr_slot_ptr preset to 4 by committing 4 packets → buf_full=1. The next packet produces no writes and drop_cnt=1. Raising rd_slot_ptr to 6 lets the next packet commit to slot 4.
- New sop at word 20 of a packet, followed by a full 47-word packet → err_cnt=1, one commit, offsets restart at 0 in the same slot.
- 1025 good packets with rd_slot_ptr tracking wr_slot_ptr → wr_slot_ptr wraps 1023→0→1. 50-word input without eop → err_cnt++ at word 47, then DROP until eop.
- With TS_SYNC_CHK_EN: a sop word 0x12345678 → no writes, err_cnt=1, drop_cnt=0. The next 0x47 packet commits. rst asserted mid-packet → all outputs 0 on the next edge.
